// File: rtl/div_dispatch_if.sv
// Bundle of request, response and divider-side signals for div_dispatch.
// The dispatcher uses the slave view; the surrounding system (requester,
// response consumer and the divider itself) uses the master view.
interface div_dispatch_if #(
   parameter int W     = 8,
   parameter int TAG_W = 4
) ();
   // request port
   logic             req_valid;
   logic             req_ready;
   logic [W-1:0]     req_a;
   logic [W-1:0]     req_b;
   logic [TAG_W-1:0] req_tag;

   // response port
   logic             rsp_valid;
   logic             rsp_ready;
   logic [W-1:0]     rsp_q;
   logic [W-1:0]     rsp_rem;
   logic [TAG_W-1:0] rsp_tag;
   logic             rsp_dbz;
   logic             rsp_err;

   // divider pins
   logic [W-1:0]     div_a;
   logic [W-1:0]     div_b;
   logic             div_start;
   logic             div_complete;
   logic [W-1:0]     div_q;

   modport master (
      output req_valid, req_a, req_b, req_tag, rsp_ready, div_complete, div_q,
      input  req_ready, rsp_valid, rsp_q, rsp_rem, rsp_tag, rsp_dbz, rsp_err,
             div_a, div_b, div_start
   );

   modport slave (
      input  req_valid, req_a, req_b, req_tag, rsp_ready, div_complete, div_q,
      output req_ready, rsp_valid, rsp_q, rsp_rem, rsp_tag, rsp_dbz, rsp_err,
             div_a, div_b, div_start
   );
endinterface

// File: rtl/div_dispatch.sv
// Issue controller in front of an 8-bit sequential divider.
// Requests are queued in a small FIFO; the FSM pops one at a time, answers
// divide-by-zero locally, otherwise launches the divider and waits for its
// complete flag (bounded by a timeout), then parks the result in a single
// response register until the consumer takes it.
module div_dispatch #(
   parameter int W       = 8,
   parameter int TAG_W   = 4,
   parameter int DEPTH   = 2,
   parameter int TIMEOUT = 32
) (
   input  logic          clock,
   input  logic          reset,
   div_dispatch_if.slave bus
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam int ENT_W = 2 * W + TAG_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      ARM    = 2'd2,
      WAIT   = 2'd3
   } state_t;

   // ---------------- request FIFO ----------------
   logic [ENT_W-1:0] fifo_mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic [ENT_W-1:0] head_reg;     // registered read of the popped entry

   logic             req_ready_int;
   logic             push;
   logic             pop;
   logic             slot_free;

   // ---------------- FSM / datapath state ----------------
   state_t           state_reg;
   logic             hold_valid_reg; // head_reg holds a popped, not-yet-dispatched request
   logic [W-1:0]     div_a_reg;
   logic [W-1:0]     div_b_reg;
   logic             div_start_reg;
   logic [TAG_W-1:0] tag_reg;
   logic [TMR_W-1:0] timer_reg;

   logic             rsp_valid_reg;
   logic [W-1:0]     rsp_q_reg;
   logic [W-1:0]     rsp_rem_reg;
   logic [TAG_W-1:0] rsp_tag_reg;
   logic             rsp_dbz_reg;
   logic             rsp_err_reg;

   logic [W-1:0]     hold_a;
   logic [W-1:0]     hold_b;
   logic [TAG_W-1:0] hold_tag;
   logic [W-1:0]     prod;
   logic [W-1:0]     rem_calc;
   logic             timed_out;

   // No pop-bypass: a full FIFO refuses even when a pop happens this cycle.
   assign req_ready_int = (count_reg != CNT_W'(DEPTH));
   assign push          = bus.req_valid && req_ready_int;

   // The slot can take a new result if empty or being drained on this edge.
   assign slot_free     = !rsp_valid_reg || bus.rsp_ready;

   // Only pop when nothing is already waiting in head_reg, so at most one
   // request is ever between the FIFO and the response slot.
   assign pop           = (state_reg == IDLE) && !hold_valid_reg &&
                          (count_reg != '0) && slot_free;

   assign hold_a   = head_reg[ENT_W-1 -: W];
   assign hold_b   = head_reg[TAG_W+W-1 -: W];
   assign hold_tag = head_reg[TAG_W-1:0];

   // Truncated W x W product; the remainder only needs the low W bits.
   assign prod      = bus.div_q * div_b_reg;
   assign rem_calc  = div_a_reg - prod;
   assign timed_out = (timer_reg == TMR_W'(TIMEOUT - 1));

   // FIFO storage write port (no reset so it maps onto RAM)
   always_ff @(posedge clock) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= {bus.req_a, bus.req_b, bus.req_tag};
      end
   end

   // FIFO registered read port, loaded on pop
   always_ff @(posedge clock) begin
      if (pop) begin
         head_reg <= fifo_mem[rd_ptr_reg];
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Dispatch FSM with registered divider pins and response slot
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         hold_valid_reg <= 1'b0;
         div_a_reg      <= '0;
         div_b_reg      <= '0;
         div_start_reg  <= 1'b0;
         tag_reg        <= '0;
         timer_reg      <= '0;
         rsp_valid_reg  <= 1'b0;
         rsp_q_reg      <= '0;
         rsp_rem_reg    <= '0;
         rsp_tag_reg    <= '0;
         rsp_dbz_reg    <= 1'b0;
         rsp_err_reg    <= 1'b0;
      end else begin
         // A drained response disappears unless a new one loads below.
         if (rsp_valid_reg && bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
         end
         if (pop) begin
            hold_valid_reg <= 1'b1;
         end

         case (state_reg)
            IDLE: begin
               if (hold_valid_reg) begin
                  hold_valid_reg <= 1'b0;
                  if (hold_b == '0) begin
                     // divide-by-zero answered without touching the divider
                     rsp_valid_reg <= 1'b1;
                     rsp_q_reg     <= '1;
                     rsp_rem_reg   <= hold_a;
                     rsp_tag_reg   <= hold_tag;
                     rsp_dbz_reg   <= 1'b1;
                     rsp_err_reg   <= 1'b0;
                  end else begin
                     div_a_reg     <= hold_a;
                     div_b_reg     <= hold_b;
                     tag_reg       <= hold_tag;
                     div_start_reg <= 1'b1;
                     state_reg     <= LAUNCH;
                  end
               end
            end

            LAUNCH: begin
               div_start_reg <= 1'b0;
               timer_reg     <= '0;
               state_reg     <= ARM;
            end

            ARM: begin
               // complete may still be high from the previous op; wait for
               // the divider to drop it before trusting it again
               if (timed_out) begin
                  rsp_valid_reg <= 1'b1;
                  rsp_q_reg     <= '0;
                  rsp_rem_reg   <= '0;
                  rsp_tag_reg   <= tag_reg;
                  rsp_dbz_reg   <= 1'b0;
                  rsp_err_reg   <= 1'b1;
                  state_reg     <= IDLE;
               end else begin
                  timer_reg <= timer_reg + TMR_W'(1);
                  if (!bus.div_complete) begin
                     state_reg <= WAIT;
                  end
               end
            end

            WAIT: begin
               if (bus.div_complete) begin
                  rsp_valid_reg <= 1'b1;
                  rsp_q_reg     <= bus.div_q;
                  rsp_rem_reg   <= rem_calc;
                  rsp_tag_reg   <= tag_reg;
                  rsp_dbz_reg   <= 1'b0;
                  rsp_err_reg   <= 1'b0;
                  state_reg     <= IDLE;
               end else if (timed_out) begin
                  rsp_valid_reg <= 1'b1;
                  rsp_q_reg     <= '0;
                  rsp_rem_reg   <= '0;
                  rsp_tag_reg   <= tag_reg;
                  rsp_dbz_reg   <= 1'b0;
                  rsp_err_reg   <= 1'b1;
                  state_reg     <= IDLE;
               end else begin
                  timer_reg <= timer_reg + TMR_W'(1);
               end
            end

            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = req_ready_int;
   assign bus.rsp_valid = rsp_valid_reg;
   assign bus.rsp_q     = rsp_q_reg;
   assign bus.rsp_rem   = rsp_rem_reg;
   assign bus.rsp_tag   = rsp_tag_reg;
   assign bus.rsp_dbz   = rsp_dbz_reg;
   assign bus.rsp_err   = rsp_err_reg;
   assign bus.div_a     = div_a_reg;
   assign bus.div_b     = div_b_reg;
   assign bus.div_start = div_start_reg;

endmodule

// File: tb/tb_div_dispatch.sv
// Bench for div_dispatch: a behavioural divider responder, an expected-
// response queue filled at request acceptance, and a per-cycle checker.
module tb_div_dispatch;

   localparam int W       = 8;
   localparam int TAG_W   = 4;
   localparam int DEPTH   = 2;
   localparam int TIMEOUT = 32;
   localparam int DLY     = 6;

   typedef struct packed {
      logic [W-1:0]     q;
      logic [W-1:0]     rem;
      logic [TAG_W-1:0] tag;
      logic             dbz;
      logic             err;
   } rsp_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   div_dispatch_if #(.W(W), .TAG_W(TAG_W)) bus ();

   div_dispatch #(.W(W), .TAG_W(TAG_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;
   int   acc_cyc     = 0;
   int   launch_cyc  = 0;
   int   arm_cyc     = 0;
   int   rise_cyc    = 0;
   int   start_pulses = 0;
   bit   hang        = 1'b0;
   rsp_t exp_q[$];
   rsp_t got_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic rsp_t mk(input logic [W-1:0] q, input logic [W-1:0] rem,
                               input logic [TAG_W-1:0] tag, input logic dbz, input logic err);
      rsp_t r;
      r.q = q; r.rem = rem; r.tag = tag; r.dbz = dbz; r.err = err;
      return r;
   endfunction

   // What the dispatcher must answer for a request, given the divider's health.
   function automatic rsp_t model_rsp(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [TAG_W-1:0] tag, input bit hung);
      if (b == '0)  return mk('1, a, tag, 1'b1, 1'b0);
      else if (hung) return mk('0, '0, tag, 1'b0, 1'b1);
      else          return mk(a / b, a % b, tag, 1'b0, 1'b0);
   endfunction

   // ---------------- divider responder ----------------
   // Start rising edge latches operands; complete drops two edges later
   // (so the old complete is still visible in ARM), then rises DLY later.
   logic         model_complete = 1'b0;
   logic [W-1:0] model_q        = '0;
   logic         start_d = 1'b0, ack = 1'b0, busy = 1'b0;
   logic [W-1:0] da = '0, db = '0;
   int           cnt = 0;
   assign bus.div_complete = model_complete;
   assign bus.div_q        = model_q;

   always @(posedge clock) begin
      start_d <= bus.div_start;
      if (bus.div_start && !start_d) begin
         ack <= 1'b1;
         da  <= bus.div_a;
         db  <= bus.div_b;
      end else if (ack) begin
         ack            <= 1'b0;
         model_complete <= 1'b0;
         busy           <= 1'b1;
         cnt            <= DLY;
      end else if (busy) begin
         if (cnt != 0) cnt <= cnt - 1;
         else if (!hang) begin
            model_complete <= 1'b1;
            model_q        <= (db != '0) ? da / db : '1;
            busy           <= 1'b0;
         end
      end
   end

   // ---------------- acceptance monitor ----------------
   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (!reset && bus.req_valid && bus.req_ready) begin
         acc_cyc <= cyc + 1;
         exp_q.push_back(model_rsp(bus.req_a, bus.req_b, bus.req_tag, hang));
      end
   end

   // A reset drops the in-flight op without a response.
   always @(posedge reset) exp_q.delete();

   // ---------------- per-cycle checker ----------------
   bit   prev_start = 1'b0, prev_valid = 1'b0, held = 1'b0;
   rsp_t held_val, cur, e;
   always @(negedge clock) begin
      if (!reset) begin
         cur = mk(bus.rsp_q, bus.rsp_rem, bus.rsp_tag, bus.rsp_dbz, bus.rsp_err);
         if (bus.div_start) begin
            chk("start_one_cycle", 32'(prev_start), 32'd0);
            if (!prev_start) begin
               launch_cyc = cyc;
               start_pulses++;
            end
         end
         if (!bus.div_start && prev_start) arm_cyc = cyc;
         if (bus.rsp_valid && !prev_valid) rise_cyc = cyc;
         if (held) chk("rsp_held_stable", 32'({bus.rsp_valid, cur}), 32'({1'b1, held_val}));
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_rsp: got 0x%0h with nothing outstanding", cur);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_model", 32'(cur), 32'(e));
            end
            got_q.push_back(cur);
         end
         held     = bus.rsp_valid && !bus.rsp_ready;
         held_val = cur;
      end else begin
         held = 1'b0;
      end
      prev_start = bus.div_start;
      prev_valid = bus.rsp_valid;
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic send_begin(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TAG_W-1:0] t);
      bus.req_a     = a;
      bus.req_b     = b;
      bus.req_tag   = t;
      bus.req_valid = 1'b1;
   endtask

   task automatic send_finish();
      int n = 0;
      while (!bus.req_ready && n < 200) begin
         tick(1);
         n++;
      end
      if (!bus.req_ready) begin
         vectors++;
         miscompares++;
         $display("FAIL send_stall: req_ready low for %0d cycles", n);
      end else begin
         tick(1);
      end
      bus.req_valid = 1'b0;
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TAG_W-1:0] t);
      send_begin(a, b, t);
      send_finish();
   endtask

   task automatic expect_got(input string name, input rsp_t want);
      int n = 0;
      while (got_q.size() == 0 && n < 300) begin
         tick(1);
         n++;
      end
      if (got_q.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL %s: no response within %0d cycles, want 0x%0h", name, n, want);
      end else begin
         rsp_t g;
         g = got_q.pop_front();
         chk(name, 32'(g), 32'(want));
      end
   endtask

   // ---------------- directed tests ----------------
   int p;
   initial begin
      bus.req_valid = 1'b0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_tag   = '0;
      bus.rsp_ready = 1'b1;

      #1 reset = 1'b1;
      #1;
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_rsp_outs", 32'({bus.rsp_valid, bus.rsp_q, bus.rsp_rem, bus.rsp_tag, bus.rsp_dbz, bus.rsp_err}), 32'd0);
      chk("rst_div_outs", 32'({bus.div_a, bus.div_b, bus.div_start}), 32'd0);
      tick(2);
      reset = 1'b0;
      tick(2);

      // 1: basic divide and launch latency
      send(8'd100, 8'd7, 4'd3);
      expect_got("t1_100_div_7", mk(8'd14, 8'd2, 4'd3, 1'b0, 1'b0));
      chk("t1_launch_latency", 32'(launch_cyc - acc_cyc), 32'd2);

      // 2: back-to-back, in order
      send(8'd255, 8'd1, 4'd1);
      send(8'd5, 8'd9, 4'd2);
      expect_got("t2_255_div_1", mk(8'd255, 8'd0, 4'd1, 1'b0, 1'b0));
      expect_got("t2_5_div_9", mk(8'd0, 8'd5, 4'd2, 1'b0, 1'b0));

      // 3: divide-by-zero answered locally
      p = start_pulses;
      send(8'd9, 8'd0, 4'd4);
      expect_got("t3_dbz", mk(8'hFF, 8'd9, 4'd4, 1'b1, 1'b0));
      chk("t3_dbz_latency", 32'(rise_cyc - acc_cyc), 32'd2);
      chk("t3_no_start", 32'(start_pulses), 32'(p));

      // 4: back-pressure, FIFO full, held response, ordered drain
      bus.rsp_ready = 1'b0;
      send(8'd20, 8'd3, 4'd5);
      send(8'd200, 8'd10, 4'd6);
      send(8'd7, 8'd7, 4'd7);
      send_begin(8'd13, 8'd0, 4'd8);
      tick(30);
      chk("t4_full_ready_low", 32'(bus.req_ready), 32'd0);
      chk("t4_first_held", 32'({bus.rsp_valid, bus.rsp_q, bus.rsp_rem, bus.rsp_tag}),
          32'({1'b1, 8'd6, 8'd2, 4'd5}));
      bus.rsp_ready = 1'b1;
      send_finish();
      expect_got("t4_rsp0", mk(8'd6, 8'd2, 4'd5, 1'b0, 1'b0));
      expect_got("t4_rsp1", mk(8'd20, 8'd0, 4'd6, 1'b0, 1'b0));
      expect_got("t4_rsp2", mk(8'd1, 8'd0, 4'd7, 1'b0, 1'b0));
      expect_got("t4_rsp3", mk(8'hFF, 8'd13, 4'd8, 1'b1, 1'b0));
      tick(10);
      chk("t4_no_extra", 32'(got_q.size()), 32'd0);

      // 5: hung divider recovered by timeout, then normal service
      hang = 1'b1;
      send(8'd77, 8'd7, 4'd9);
      expect_got("t5_timeout", mk(8'd0, 8'd0, 4'd9, 1'b0, 1'b1));
      chk("t5_timeout_cycles", 32'(rise_cyc - arm_cyc), 32'(TIMEOUT));
      hang = 1'b0;
      send(8'd77, 8'd7, 4'd10);
      expect_got("t5_recover", mk(8'd11, 8'd0, 4'd10, 1'b0, 1'b0));

      // 6: reset while waiting on the divider
      send(8'd100, 8'd3, 4'd11);
      tick(7);
      reset = 1'b1;
      #1;
      chk("t6_rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("t6_rst_rsp_outs", 32'({bus.rsp_valid, bus.rsp_q, bus.rsp_rem, bus.rsp_tag, bus.rsp_dbz, bus.rsp_err}), 32'd0);
      chk("t6_rst_div_outs", 32'({bus.div_a, bus.div_b, bus.div_start}), 32'd0);
      tick(3);
      reset = 1'b0;
      tick(15);
      chk("t6_dropped", 32'(got_q.size()), 32'd0);
      send(8'd50, 8'd5, 4'd12);
      expect_got("t6_after_reset", mk(8'd10, 8'd0, 4'd12, 1'b0, 1'b0));

      tick(20);
      chk("end_exp_empty", 32'(exp_q.size()), 32'd0);
      chk("end_got_empty", 32'(got_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
